mem_port_arbiter: RTL and testbench

- Shares the single-port memory between the instruction-fetch requester and the data-access requester of the multicycle datapath.
- Each requester uses the MOV/MOC handshake: hold a request, receive a one-cycle completion pulse.
- The block latches the winning request and drives the memory. It returns read data and a one-cycle completion or error pulse to the winner.
- A watchdog aborts accesses that the memory never completes.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Latches the winning request, drives the memory, and returns data plus a completion/error pulse.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mov,
    input  logic [31:0] i_addr,
    output logic        i_moc,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_mov,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_moc,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_moc,
    output logic [2:0]  dbg_state_o
);

    // MOV/MOC handshake: a requester raises mov with stable fields and holds it until it
    // sees a one-cycle moc (done) or err (aborted) pulse; it must then drop mov before
    // the same port can be granted again. The memory side uses the same handshake.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BUS_I = 3'd1;
    localparam logic [2:0] ST_BUS_D = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DROP  = 3'd4;

    localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

    logic [2:0]      state_q, state_d;
    logic            gnt_d_q, gnt_d_d;
    logic            last_d_q, last_d_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            mem_mov_q, mem_mov_d;
    logic            mem_rw_q, mem_rw_d;
    logic [1:0]      mem_size_q, mem_size_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            i_moc_q, i_moc_d, i_err_q, i_err_d;
    logic            d_moc_q, d_moc_d, d_err_q, d_err_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    logic [TO_W:0]   cnt_inc;
    logic            timeout_hit;
    logic            pick_d;
    logic            held;

    assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIM);
    // Both pending: the port not served last wins; last_d_q resets to 1 so I wins the first tie.
    assign pick_d      = d_mov && (!i_mov || !last_d_q);
    assign held        = gnt_d_q ? d_mov : i_mov;

    always_comb begin
        state_d     = state_q;
        gnt_d_d     = gnt_d_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_mov_d   = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_moc_d     = 1'b0;
        i_err_d     = 1'b0;
        d_moc_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_mov || d_mov) begin
                    gnt_d_d   = pick_d;
                    cnt_d     = '0;
                    mem_mov_d = 1'b1;
                    if (pick_d) begin
                        mem_rw_d    = d_rw;
                        mem_size_d  = (d_size == 2'b11) ? 2'b10 : d_size;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        state_d     = ST_BUS_D;
                    end else begin
                        mem_rw_d    = 1'b1;
                        mem_size_d  = 2'b10;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        state_d     = ST_BUS_I;
                    end
                end
            end
            ST_BUS_I, ST_BUS_D: begin
                // Completion takes priority over a watchdog expiry at the same edge.
                if (mem_moc) begin
                    state_d = ST_RESP;
                    if (gnt_d_q) begin
                        d_moc_d = 1'b1;
                        if (mem_rw_q) d_rdata_d = mem_rdata;
                    end else begin
                        i_moc_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    if (gnt_d_q) d_err_d = 1'b1;
                    else         i_err_d = 1'b1;
                end else begin
                    mem_mov_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                last_d_d = gnt_d_q;
                state_d  = ST_DROP;
            end
            ST_DROP: begin
                if (!held) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_d_q     <= 1'b0;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            mem_mov_q   <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_size_q  <= 2'b10;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_moc_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_moc_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_d_q     <= gnt_d_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_mov_q   <= mem_mov_d;
            mem_rw_q    <= mem_rw_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_moc_q     <= i_moc_d;
            i_err_q     <= i_err_d;
            d_moc_q     <= d_moc_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_moc       = i_moc_q;
    assign i_err       = i_err_q;
    assign i_rdata     = i_rdata_q;
    assign d_moc       = d_moc_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;
    assign mem_mov     = mem_mov_q;
    assign mem_rw      = mem_rw_q;
    assign mem_size    = mem_size_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: the bench plays both requesters and the memory, and predicts
// grant order, bus fields, bus cycle count, pulse kind and returned data per round.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_mov, i_moc, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_mov, d_rw, d_moc, d_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_mov, mem_rw, mem_moc;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  dbg_state_o;

    mem_port_arbiter #(.TIMEOUT(TO), .TO_W(3)) dut (
        .clk(clk), .reset(reset),
        .i_mov(i_mov), .i_addr(i_addr), .i_moc(i_moc), .i_err(i_err), .i_rdata(i_rdata),
        .d_mov(d_mov), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_moc(d_moc), .d_err(d_err), .d_rdata(d_rdata),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // round stimulus fields
    logic [31:0] ia, da, dw, rd_i, rd_d;
    logic        drw;
    logic [1:0]  dsz;
    int          lat_i, lat_d;

    // reference model state
    logic        last_d_m;
    logic [31:0] i_rdata_m, d_rdata_m;

    // memory responder state; latency 0 means the memory never answers
    int          lat_q[$];
    logic [31:0] rd_q[$];
    bit          acc_active;
    int          acc_cnt, cur_lat;
    logic [31:0] cur_rd;
    bit          stray_en;

    // scoreboard
    logic [31:0] exp_q[$];
    logic [3:0]  exp_pulse_q[$];
    int          exp_cyc_q[$];
    bit          ord_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mem_respond();
        if (mem_mov) begin
            if (!acc_active) begin
                acc_active = 1'b1;
                acc_cnt    = 0;
                if (lat_q.size() > 0) begin
                    cur_lat = lat_q.pop_front();
                    cur_rd  = rd_q.pop_front();
                end else begin
                    cur_lat = 1;
                    cur_rd  = 32'h0;
                    check("unexpected_grant", 32'd1, 32'd0);
                end
            end
            acc_cnt++;
            mem_moc   = (cur_lat != 0) && (acc_cnt == cur_lat);
            mem_rdata = mem_moc ? cur_rd : $urandom;
        end else begin
            acc_active = 1'b0;
            mem_moc    = stray_en && ($urandom_range(0, 3) == 0);
            mem_rdata  = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mem_respond();
    endtask

    task automatic run_round(input bit use_i, input bit use_d);
        int  n, k, mc, h;
        bit  p, ok;
        int  lat;
        logic [31:0] rd;
        logic [3:0]  pv;
        ord_q.delete(); exp_q.delete(); exp_pulse_q.delete(); exp_cyc_q.delete();
        if (use_i && use_d) begin
            ord_q.push_back(last_d_m ? 1'b0 : 1'b1);
            ord_q.push_back(last_d_m ? 1'b1 : 1'b0);
        end else begin
            ord_q.push_back(use_d);
        end
        n = ord_q.size();
        foreach (ord_q[j]) begin
            p   = ord_q[j];
            lat = p ? lat_d : lat_i;
            rd  = p ? rd_d : rd_i;
            lat_q.push_back(lat);
            rd_q.push_back(rd);
            ok = (lat != 0) && (lat <= TO);
            exp_cyc_q.push_back(ok ? lat : TO);
            if (!p) begin
                if (ok) i_rdata_m = rd;
                exp_q.push_back(i_rdata_m);
                exp_pulse_q.push_back(ok ? 4'b1000 : 4'b0100);
            end else begin
                if (ok && drw) d_rdata_m = rd;
                exp_q.push_back(d_rdata_m);
                exp_pulse_q.push_back(ok ? 4'b0010 : 4'b0001);
            end
        end
        i_mov = use_i; i_addr = ia;
        d_mov = use_d; d_rw = drw; d_size = dsz; d_addr = da; d_wdata = dw;
        k = 0; mc = 0;
        for (int cyc = 0; cyc < 100 && k < n; cyc++) begin
            tick();
            if (mem_mov) begin
                if (mc == 0) begin
                    if (ord_q[k]) begin
                        check("bus_addr_d", mem_addr, da);
                        check("bus_rw_d", {31'd0, mem_rw}, {31'd0, drw});
                        check("bus_size_d", {30'd0, mem_size}, (dsz == 2'b11) ? 32'd2 : {30'd0, dsz});
                        check("bus_wdata_d", mem_wdata, dw);
                    end else begin
                        check("bus_addr_i", mem_addr, ia);
                        check("bus_rw_i", {31'd0, mem_rw}, 32'd1);
                        check("bus_size_i", {30'd0, mem_size}, 32'd2);
                    end
                end
                mc++;
            end
            pv = {i_moc, i_err, d_moc, d_err};
            if (pv != 4'b0000) begin
                check("pulse", {28'd0, pv}, {28'd0, exp_pulse_q[k]});
                check("rdata", ord_q[k] ? d_rdata : i_rdata, exp_q[k]);
                check("bus_cycles", 32'(mc), 32'(exp_cyc_q[k]));
                h = $urandom_range(1, 3);
                repeat (h) begin
                    tick();
                    check("no_regrant", {27'd0, mem_mov, i_moc, i_err, d_moc, d_err}, 32'd0);
                end
                if (ord_q[k]) d_mov = 1'b0;
                else          i_mov = 1'b0;
                k++;
                mc = 0;
            end
        end
        if (k < n) check("round_budget", 32'(k), 32'(n));
        i_mov = 1'b0; d_mov = 1'b0;
        last_d_m = ord_q[n-1];
        tick();
        tick();
        check("idle_i_rdata", i_rdata, i_rdata_m);
        check("idle_d_rdata", d_rdata, d_rdata_m);
    endtask

    task automatic rand_fields();
        ia    = $urandom;
        da    = $urandom;
        dw    = $urandom;
        rd_i  = $urandom;
        rd_d  = $urandom;
        drw   = 1'($urandom_range(0, 1));
        dsz   = 2'($urandom_range(0, 3));
        lat_i = $urandom_range(0, 6);
        lat_d = $urandom_range(0, 6);
    endtask

    initial begin
        reset = 1'b1;
        i_mov = 1'b0; i_addr = '0;
        d_mov = 1'b0; d_rw = 1'b1; d_size = 2'b10; d_addr = '0; d_wdata = '0;
        mem_moc = 1'b0; mem_rdata = '0;
        acc_active = 1'b0; stray_en = 1'b0;
        last_d_m = 1'b1; i_rdata_m = '0; d_rdata_m = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_mov", {31'd0, mem_mov}, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("rst_mem_size", {30'd0, mem_size}, 32'd2);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_pulses", {28'd0, i_moc, i_err, d_moc, d_err}, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        check("rst_state_idle", {29'd0, dbg_state_o}, 32'd0);
        reset = 1'b0;
        tick();

        // fetch only
        rand_fields();
        ia = 32'h40; rd_i = 32'h8C220004; lat_i = 3;
        run_round(1'b1, 1'b0);
        // byte write
        rand_fields();
        drw = 1'b0; dsz = 2'b00; da = 32'h103; dw = 32'hAB; lat_d = 2;
        run_round(1'b0, 1'b1);
        // contention twice: I, D, I, D
        repeat (2) begin
            rand_fields();
            lat_i = 1; lat_d = 2;
            run_round(1'b1, 1'b1);
        end
        // watchdog abort, then completion exactly at the limit
        rand_fields();
        drw = 1'b1; lat_d = 0;
        run_round(1'b0, 1'b1);
        rand_fields();
        drw = 1'b1; lat_d = TO;
        run_round(1'b0, 1'b1);

        // randomized rounds with stray mem_moc outside accesses
        stray_en = 1'b1;
        repeat (40) begin
            rand_fields();
            case ($urandom_range(0, 2))
                0:       run_round(1'b1, 1'b0);
                1:       run_round(1'b0, 1'b1);
                default: run_round(1'b1, 1'b1);
            endcase
        end
        stray_en = 1'b0;

        // reset during a data access that the memory never completes
        rand_fields();
        lat_q.push_back(0); rd_q.push_back(32'h0);
        d_mov = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = da; d_wdata = dw;
        repeat (3) tick();
        check("bus_before_reset", {31'd0, mem_mov}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst_mem_mov", {31'd0, mem_mov}, 32'd0);
        check("midrst_pulses", {28'd0, i_moc, i_err, d_moc, d_err}, 32'd0);
        check("midrst_rdata", i_rdata | d_rdata, 32'd0);
        d_mov = 1'b0;
        lat_q.delete(); rd_q.delete();
        acc_active = 1'b0;
        last_d_m = 1'b1; i_rdata_m = '0; d_rdata_m = '0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        rand_fields();
        lat_i = 2; lat_d = 1;
        run_round(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
